bcd_score_accum: RTL and testbench

Parametrised BCD score accumulator for the Tetris scoring path. It supersedes the fixed 3-digit, edge-triggered score counter. It runs on the system clock with a valid/ready event handshake. Each line-clear event adds a squared-lines point value multiplied by the current BCD level, using repeated BCD addition. It saturates at all-nines and keeps a high-score register across games. Outputs feed the 7-segment score display directly in packed BCD.

---
 rtl/bcd_score_accum.sv | 127 ++++++++++++
 tb/tb_bcd_score_accum.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_accum.sv
// BCD score accumulator: line-clear events add (lines^2 * level) to a packed
// BCD score by repeated ripple BCD addition, saturating at all nines, and
// track the best score seen since reset.
module bcd_score_accum #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic [1:0]            evt_lines,
    input  logic [7:0]            level,
    input  logic                  new_game,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hi_score,
    output logic                  sat,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;

    logic [1:0]   state;
    logic [7:0]   points;
    logic [7:0]   cnt;
    logic [7:0]   cnt_dec;
    logic [7:0]   pts_sel;
    logic [W-1:0] pts_ext;
    logic [W-1:0] sum;
    logic [W-1:0] hi_max;
    logic [W-1:0] nines;
    logic [4:0]   dsum;
    logic         carry;

    assign evt_ready = (state == IDLE);
    assign nines     = {DIGITS{4'h9}};
    assign pts_ext   = W'(points);
    // Packed BCD compares correctly as plain unsigned binary.
    assign hi_max    = (score > hi_score) ? score : hi_score;

    // Squared line count as a packed BCD point value.
    always_comb begin
        pts_sel = 8'h01;
        case (evt_lines)
            2'b00:   pts_sel = 8'h01;
            2'b01:   pts_sel = 8'h04;
            2'b10:   pts_sel = 8'h09;
            default: pts_sel = 8'h16;
        endcase
    end

    // BCD decrement of the remaining add count: borrow turns a 0 digit into 9.
    always_comb begin
        if (cnt[3:0] == 4'h0) cnt_dec = {cnt[7:4] - 4'd1, 4'h9};
        else                  cnt_dec = {cnt[7:4], cnt[3:0] - 4'd1};
    end

    // Ripple BCD adder: score + points; carry out of the top digit means overflow.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        dsum  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, score[4*i +: 4]} + {1'b0, pts_ext[4*i +: 4]} + {4'd0, carry};
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = dsum[3:0];
        end
    end

    // Control FSM and score/high-score state; new_game overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            points   <= '0;
            cnt      <= '0;
            score    <= '0;
            hi_score <= '0;
            sat      <= 1'b0;
            done     <= 1'b0;
        end else if (new_game) begin
            hi_score <= hi_max;
            score    <= '0;
            sat      <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (evt_valid) begin
                        points <= pts_sel;
                        // Level 0 still scores once.
                        cnt    <= (level == 8'h00) ? 8'h01 : level;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    // Once saturated, stay pinned at all nines for the rest of the game.
                    if (sat || carry) begin
                        score <= nines;
                        sat   <= 1'b1;
                    end else begin
                        score <= sum;
                    end
                    cnt <= cnt_dec;
                    if (cnt == 8'h01) state <= CMP;
                end
                CMP: begin
                    hi_score <= hi_max;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_score_accum.sv
// Directed bench for bcd_score_accum: a DIGITS=4 and a DIGITS=2 instance,
// decimal reference model, expected event results queued at acceptance and
// checked when done pulses.
module tb_bcd_score_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  evt_lines;
    logic [7:0]  level;
    logic        valid4, valid2, ng4, ng2;
    logic        ready4, ready2, sat4, sat2, done4, done2;
    logic [15:0] score4, hi4;
    logic [7:0]  score2, hi2;

    int checks = 0;
    int fails  = 0;

    // Reference model state (decimal integers)
    int m_score4 = 0, m_hi4 = 0, m_score2 = 0, m_hi2 = 0;
    bit m_sat4 = 0, m_sat2 = 0;

    typedef struct {
        logic [31:0] score;
        logic [31:0] hi;
        logic        sat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_score_accum #(.DIGITS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .evt_valid(valid4), .evt_ready(ready4),
        .evt_lines(evt_lines), .level(level), .new_game(ng4),
        .score(score4), .hi_score(hi4), .sat(sat4), .done(done4)
    );

    bcd_score_accum #(.DIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .evt_valid(valid2), .evt_ready(ready2),
        .evt_lines(evt_lines), .level(level), .new_game(ng2),
        .score(score2), .hi_score(hi2), .sat(sat2), .done(done2)
    );

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs_score(input bit two);
        return two ? {24'd0, score2} : {16'd0, score4};
    endfunction

    // Drive one event, check per-cycle progress, ready window and done latency.
    task automatic run_event(input bit two, input logic [1:0] lines, input logic [7:0] lvl);
        int   pts, lv, start, maxv, total;
        exp_t e, got;
        pts   = (int'(lines) + 1) * (int'(lines) + 1);
        lv    = int'(lvl[7:4]) * 10 + int'(lvl[3:0]);
        if (lv == 0) lv = 1;
        maxv  = two ? 99 : 9999;
        start = two ? m_score2 : m_score4;
        total = start + pts * lv;

        chk("ready_before", {31'd0, two ? ready2 : ready4}, 32'd1);
        evt_lines = lines;
        level     = lvl;
        if (two) valid2 = 1'b1; else valid4 = 1'b1;
        tick();
        // Acceptance: queue the expected final result and advance the model.
        e.score = to_bcd(imin(total, maxv));
        if (two) begin
            m_sat2   = m_sat2 || (total > maxv);
            m_score2 = imin(total, maxv);
            m_hi2    = imax(m_hi2, m_score2);
            e.hi = to_bcd(m_hi2); e.sat = m_sat2;
        end else begin
            m_sat4   = m_sat4 || (total > maxv);
            m_score4 = imin(total, maxv);
            m_hi4    = imax(m_hi4, m_score4);
            e.hi = to_bcd(m_hi4); e.sat = m_sat4;
        end
        sb.push_back(e);
        valid2 = 1'b0; valid4 = 1'b0;
        // Scrambled inputs must not affect the in-flight event.
        evt_lines = ~lines;
        level     = 8'h37;

        chk("ready_low_accept", {31'd0, two ? ready2 : ready4}, 32'd0);
        chk("done_low_accept",  {31'd0, two ? done2 : done4},  32'd0);
        for (int i = 1; i <= lv; i++) begin
            tick();
            chk($sformatf("add_step%0d", i), obs_score(two), to_bcd(imin(start + pts * i, maxv)));
            chk("ready_low_add", {31'd0, two ? ready2 : ready4}, 32'd0);
        end
        tick();
        chk("done_pulse", {31'd0, two ? done2 : done4},  32'd1);
        chk("ready_back", {31'd0, two ? ready2 : ready4}, 32'd1);
        if (sb.size() == 0) begin
            checks++; fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = sb.pop_front();
            chk("final_score", obs_score(two), got.score);
            chk("final_hi", two ? {24'd0, hi2} : {16'd0, hi4}, got.hi);
            chk("final_sat", {31'd0, two ? sat2 : sat4}, {31'd0, got.sat});
        end
        tick();
        chk("done_one_cycle", {31'd0, two ? done2 : done4}, 32'd0);
    endtask

    task automatic new_game4();
        ng4 = 1'b1;
        tick();
        ng4 = 1'b0;
        m_hi4 = imax(m_hi4, m_score4); m_score4 = 0; m_sat4 = 0;
        chk("ng_score", {16'd0, score4}, 32'd0);
        chk("ng_hi", {16'd0, hi4}, to_bcd(m_hi4));
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; valid4 = 0; valid2 = 0; ng4 = 0; ng2 = 0;
        evt_lines = 2'b00; level = 8'h00;
        #12;
        chk("rst_score", {16'd0, score4}, 32'd0);
        chk("rst_hi",    {16'd0, hi4},    32'd0);
        chk("rst_ready", {31'd0, ready4}, 32'd1);
        chk("rst_done",  {31'd0, done4},  32'd0);
        chk("rst_sat",   {31'd0, sat4},   32'd0);
        rst_n = 1'b1;
        tick();

        // Single event: 4 lines at level 1
        run_event(0, 2'b11, 8'h01);
        new_game4();
        // BCD carry across digits: 9 points x level 12
        run_event(0, 2'b10, 8'h12);
        new_game4();
        // Level 0 behaves as level 1
        run_event(0, 2'b01, 8'h00);
        new_game4();

        // Saturation on the 2-digit instance: 9x10=90, then +16 overflows
        run_event(1, 2'b10, 8'h10);
        run_event(1, 2'b11, 8'h01);
        chk("sat2_flag", {31'd0, sat2}, 32'd1);
        run_event(1, 2'b00, 8'h03);

        // new_game mid-ADD: build 0x0200, start level-50 event, clear after one add
        run_event(0, 2'b01, 8'h50);
        evt_lines = 2'b11; level = 8'h50; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        tick();
        chk("mid_add_score", {16'd0, score4}, 32'h0216);
        ng4 = 1'b1; valid4 = 1'b1;
        tick();
        ng4 = 1'b0; valid4 = 1'b0;
        m_hi4 = imax(m_hi4, 216); m_score4 = 0; m_sat4 = 0;
        chk("abort_score", {16'd0, score4}, 32'd0);
        chk("abort_sat",   {31'd0, sat4},   32'd0);
        chk("abort_ready", {31'd0, ready4}, 32'd1);
        chk("abort_hi",    {16'd0, hi4},    32'h0216);
        saw_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done4) saw_done = 1;
            tick();
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_idle_score", {16'd0, score4}, 32'd0);

        // Async reset mid-ADD, asserted between clock edges
        run_event(0, 2'b11, 8'h02);
        evt_lines = 2'b00; level = 8'h20; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_score", {16'd0, score4}, 32'd0);
        chk("arst_hi",    {16'd0, hi4},    32'd0);
        chk("arst_ready", {31'd0, ready4}, 32'd1);
        chk("arst_sat",   {31'd0, sat4},   32'd0);
        chk("arst_done",  {31'd0, done4},  32'd0);
        chk("arst_hi2",   {24'd0, hi2},    32'd0);
        #3 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
